// File: rtl/pipe_reg_elastic_if.sv
// rtl/pipe_reg_elastic_if.sv - valid/ready/data handshake bundle for elastic stage registers
interface pipe_reg_elastic_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic stage register with two-entry skid buffer and registered in_ready
// Optional stall/flush performance counters enabled by defining PIPE_REG_PERF_EN.
module pipe_reg_elastic #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_reg_elastic_if.slave    in_if,
  pipe_reg_elastic_if.master   out_if,
  output logic [1:0]           occupancy
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
`endif
);

  // Encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       occupancy_q, occupancy_d;
  logic             accept;
  logic             release_x;

  assign accept    = in_if.valid && in_ready_q;
  assign release_x = state_q[0] && out_if.ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        out_data_d  = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = FULL1;
            out_data_d = in_if.data;
          end
        end
        FULL1: begin
          if (accept && release_x) begin
            out_data_d = in_if.data;
          end else if (accept) begin
            state_d     = FULL2;
            skid_data_d = in_if.data;
          end else if (release_x) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (release_x) begin
            state_d    = FULL1;
            out_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // in_ready and occupancy are precomputed from the next state so both leave the block as flops.
    in_ready_d = (state_d != FULL2);
    case (state_d)
      FULL1:   occupancy_d = 2'd1;
      FULL2:   occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = state_q[0];
  assign out_if.data  = out_data_q;
  assign occupancy    = occupancy_q;

`ifdef PIPE_REG_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [16:0] flush_sum;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_sum   = {1'b0, flush_cnt_q} + {15'd0, occupancy_q};
    if (state_q[0] && !out_if.ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush) begin
      flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_reg_elastic.md
# pipe_reg_elastic

Parametrised elastic pipeline register for the pipelined core: the next generation of the fixed-field stage registers between decode and execute (and the other stage boundaries). It carries an arbitrary-width payload with a valid/ready handshake, a two-entry skid buffer so `in_ready` is registered, a synchronous flush, and a selectable flush-clear mode. One instance replaces one fixed-format stage register. Stall comes from back-pressure, not a separate enable.

## Interface
Parameters:
- `WIDTH`, 32: payload bits. Stage fields are concatenated by the instantiating stage. Legal range 1..256.
- `CLEAR_ON_FLUSH`, 1: 1 zeroes stored payloads on flush or reset. 0 clears only valid bits; data registers keep stale values.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous kill of all held and incoming entries.
- `in_valid`  input  1  upstream has a payload.
- `in_ready`  output  1  registered; this block can accept a payload this cycle.
- `in_data`  input  WIDTH  upstream payload.
- `out_valid`  output  1  `out_data` holds a live entry.
- `out_ready`  input  1  downstream accepts this cycle.
- `out_data`  output  WIDTH  head payload, driven directly from a register.
- `occupancy`  output  2  number of live entries, 0..2.
- `stall_cnt`  output  16  only with `PIPE_REG_PERF_EN`: cycles with `out_valid && !out_ready`.
- `flush_cnt`  output  16  only with `PIPE_REG_PERF_EN`: live entries killed by flush.

## Operation
Storage:
- Two entries: main (`out_data`/`out_valid`) and skid (`skid_data`/`skid_valid`).
- `in_ready` is the registered value of `!skid_valid` as it will be next cycle.

Handshakes:
- Accept: `in_valid && in_ready`.
- Release: `out_valid && out_ready`.

States, encoded by `{skid_valid, out_valid}`. No other encoding is reachable.

EMPTY (00):
- Accept → FULL1; main ← `in_data`.

FULL1 (01):
- Accept and release → stay FULL1; main ← `in_data`.
- Accept, no release → FULL2; skid ← `in_data`; `in_ready` drops next cycle.
- Release only → EMPTY.

FULL2 (11):
- `in_ready` is 0, so no accept is possible.
- Release → FULL1; main ← skid; skid cleared; `in_ready` rises next cycle.
- No release → hold.

Flush:
- Highest priority. On a cycle with `flush=1`, the next state is EMPTY regardless of the handshakes.
- Any accept in that cycle is discarded.
- A release in that cycle is still a completed transfer; downstream already sampled it.
- If `CLEAR_ON_FLUSH=1`, both data registers become 0. If 0, data registers hold.
- `in_ready` is 1 the cycle after a flush.

Ordering:
- Strict FIFO; no entry is ever duplicated or dropped except by flush.

`occupancy`:
- EMPTY=0, FULL1=1, FULL2=2.

Counters (macro only):
- 16-bit, saturating at 0xFFFF.
- `flush_cnt` adds `occupancy` (0, 1 or 2) per flush cycle. Entries released in the flush cycle are still counted.

## Timing
- Reset (asynchronous assert, release on `clk` edge):
  - `out_valid`=0, `out_data`=0, skid cleared.
  - `in_ready`=1, `occupancy`=0, counters 0.
  - Applies regardless of `CLEAR_ON_FLUSH`.
- Reset asserted mid-transfer: all entries lost immediately, no partial update.
- Latency: an accept at edge N appears on `out_data`/`out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 transfer per cycle sustained while `out_ready=1`.
- After `out_ready` falls, the block absorbs exactly one more payload before `in_ready` falls.
- Every output is a flop output; there are no combinational input-to-output paths.
- Simultaneous `flush` and reset: reset wins.

## Configuration
- `PIPE_REG_PERF_EN` defined:
  - `stall_cnt` and `flush_cnt` ports exist and count as described.
- Not defined:
  - Both ports and their counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset then stream: `in_valid=1`, `out_ready=1`, `in_data`=1,2,3,… → `out_data`=1,2,3,… one cycle later. `in_ready` stays 1 and `occupancy` stays 1.
- Back-pressure: send A, B, C with `out_ready=0` → A in main, B in skid, `in_ready`=0, `occupancy`=2, C held upstream. Raise `out_ready` → outputs A, B, C in order with no gaps after the first release.
- Flush in FULL2 with `in_valid=1`, `in_data`=0xDEAD, `CLEAR_ON_FLUSH=1` → next cycle `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=1. 0xDEAD never appears; `flush_cnt`=2 with the macro defined.
- `CLEAR_ON_FLUSH=0`, flush in FULL1 holding 0x55 → `out_valid`=0, `out_data` stays 0x55, and no release ever occurs.
- Reset asserted asynchronously between edges while in FULL2 → outputs go to reset values before the next edge.
- With macro: hold `out_valid=1`, `out_ready=0` for 70000 cycles → `stall_cnt` saturates at 0xFFFF.
